// File: rtl/seg7_scan_decoder_pkg.sv
// Shared types and constants for the 7-segment scan decoder.
// Segment encoding is bit6..bit0 = a..g, active-high, matching the driver side.
package seg7_pkg;

    localparam int CNT_W = 4;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } stateT;

    typedef struct packed {
        logic [6:0] value;
        logic       patternErr;
        logic       rangeErr;
    } resultT;

endpackage

// File: rtl/seg7_scan_decoder_if.sv
// Sample bus in, decoded result out on a valid/ready handshake.
interface seg7_scan_decoder_if;

    logic       segValid;
    logic       digitSel;
    logic [6:0] segIn;
    logic       outValid;
    logic       outReady;
    logic [6:0] binaryOutput;
    logic       patternErr;
    logic       rangeErr;

    modport master (
        output segValid, digitSel, segIn, outReady,
        input  outValid, binaryOutput, patternErr, rangeErr
    );

    modport slave (
        input  segValid, digitSel, segIn, outReady,
        output outValid, binaryOutput, patternErr, rangeErr
    );

endinterface

// File: rtl/seg7_digit_decode.sv
// Combinational 7-segment pattern to digit decode; any non-digit pattern
// (blank included) is reported through legal=0.
module seg7_digit_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] digit,
    output logic       legal
);

    always_comb begin
        digit = 4'd0;
        legal = 1'b1;
        case (pattern)
            SEG_0:   digit = 4'd0;
            SEG_1:   digit = 4'd1;
            SEG_2:   digit = 4'd2;
            SEG_3:   digit = 4'd3;
            SEG_4:   digit = 4'd4;
            SEG_5:   digit = 4'd5;
            SEG_6:   digit = 4'd6;
            SEG_7:   digit = 4'd7;
            SEG_8:   digit = 4'd8;
            SEG_9:   digit = 4'd9;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Two-digit multiplexed 7-segment bus receiver: per-digit stability filter,
// decode to 0..99, one result per new locked pair. Option: SEG_ACTIVE_LOW_EN.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int STABLE_CNT = 3
) (
    input  logic               clk,
    input  logic               rst,
    seg7_scan_decoder_if.slave bus
);

    localparam int NUM_DIGITS = 2;
    localparam logic [CNT_W-1:0] LOCK_CNT = CNT_W'(STABLE_CNT);

    logic [6:0]                            sample;
    logic [NUM_DIGITS-1:0][6:0]            hold;
    logic [NUM_DIGITS-1:0][CNT_W-1:0]      cnt;
    logic [NUM_DIGITS-1:0]                 locked;
    logic [NUM_DIGITS-1:0][3:0]            digitVal;
    logic [NUM_DIGITS-1:0]                 legal;
    logic [13:0]                           curPair;
    logic [13:0]                           lastPair;
    logic                                  pairSeen;
    logic [6:0]                            tensOnes;
    resultT                                nextRes;
    resultT                                res;
    stateT                                 state;
    stateT                                 nextState;
    logic                                  emitFire;

    // Everything downstream, including stored pairs, sees active-high patterns.
`ifdef SEG_ACTIVE_LOW_EN
    assign sample = ~bus.segIn;
`else
    assign sample = bus.segIn;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            hold <= '0;
            cnt  <= '0;
        end else if (bus.segValid) begin
            for (int d = 0; d < NUM_DIGITS; d++) begin
                if (int'(bus.digitSel) == d) begin
                    if (sample == hold[d]) begin
                        if (cnt[d] != LOCK_CNT) cnt[d] <= cnt[d] + 1'b1;
                    end else begin
                        hold[d] <= sample;
                        cnt[d]  <= CNT_W'(1);
                    end
                end
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_DIGITS; g++) begin : gDigit
            assign locked[g] = (cnt[g] == LOCK_CNT);
            seg7_digit_decode uDec (
                .pattern (hold[g]),
                .digit   (digitVal[g]),
                .legal   (legal[g])
            );
        end
    endgenerate

    assign curPair = {hold[0], hold[1]};

    always_comb begin
        tensOnes            = 7'(digitVal[0]) * 7'd10 + 7'(digitVal[1]);
        nextRes.patternErr  = ~&legal;
        nextRes.value       = nextRes.patternErr ? 7'd0 : tensOnes;
        nextRes.rangeErr    = ~nextRes.patternErr && (tensOnes > 7'd63);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    // A locked pair identical to the last emitted one is never re-emitted.
    always_comb begin
        nextState = state;
        emitFire  = 1'b0;
        case (state)
            IDLE: if (&locked && (!pairSeen || curPair != lastPair)) begin
                nextState = EMIT;
                emitFire  = 1'b1;
            end
            EMIT: if (bus.outReady) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        bus.outValid     = (state == EMIT);
        bus.binaryOutput = res.value;
        bus.patternErr   = res.patternErr;
        bus.rangeErr     = res.rangeErr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res      <= '0;
            lastPair <= '0;
            pairSeen <= 1'b0;
        end else if (emitFire) begin
            res      <= nextRes;
            lastPair <= curPair;
            pairSeen <= 1'b1;
        end
    end

endmodule
